inst_stream_encoder: RTL

Instruction encoder and streaming source for single-instruction checking and directed simulation. It accepts decoded instruction requests (operation select, register fields and immediate) and encodes each one into a legal 32-bit RV32IM word. Only operations in the checker's allowed set are encodable. Encoded words are buffered in a small FIFO and presented to the fetch-side injection point with a valid/ready handshake. When the FIFO is empty, the output carries the stall NOP (32'h0000007F) with valid low.

---
 rtl/inst_stream_encoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/inst_stream_encoder.sv
// RV32IM instruction encoder feeding a small valid/ready FIFO toward the fetch injection point.
// Optional build macro INST_ENC_LFSR_EN adds rand_mode and an LFSR-driven self-enqueue source.
module inst_stream_encoder #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef INST_ENC_LFSR_EN
   input  logic             rand_mode,
`endif
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       req_op,
   input  logic [4:0]       req_rd,
   input  logic [4:0]       req_rs1,
   input  logic [4:0]       req_rs2,
   input  logic [31:0]      req_imm,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      instruction,
   output logic [CNT_W-1:0] emit_count,
   output logic             err_illegal
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [31:0] STALL_NOP = 32'h0000007F;

   logic [AW:0]  wr_ptr, rd_ptr;
   logic [31:0]  mem [DEPTH];
   logic         full, empty, push, pop, err_set;

   logic [5:0]   src_op;
   logic [4:0]   src_rd, src_rs1, src_rs2;
   logic [31:0]  src_imm;
   logic         src_push;
   logic [31:0]  enc_word;
   logic         enc_legal;
   logic [2:0]   f3;
   logic [6:0]   f7;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef INST_ENC_LFSR_EN
   logic [31:0] lfsr;
   logic [5:0]  rand_op;

   // Fibonacci form of x^32+x^22+x^2+x+1, free-running regardless of rand_mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 32'hACE12468;
      else        lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
   end

   assign rand_op   = (lfsr[5:0] < 6'd35) ? lfsr[5:0] : lfsr[5:0] - 6'd35;
   assign req_ready = !full && !rand_mode;

   always_comb begin
      if (rand_mode) begin
         src_op = rand_op;   src_rd = lfsr[10:6];  src_rs1 = lfsr[15:11];
         src_rs2 = lfsr[20:16]; src_imm = lfsr;    src_push = !full;
      end else begin
         src_op = req_op;    src_rd = req_rd;      src_rs1 = req_rs1;
         src_rs2 = req_rs2;  src_imm = req_imm;    src_push = req_valid && req_ready;
      end
   end
`else
   assign req_ready = !full;
   assign src_op    = req_op;
   assign src_rd    = req_rd;
   assign src_rs1   = req_rs1;
   assign src_rs2   = req_rs2;
   assign src_imm   = req_imm;
   assign src_push  = req_valid && req_ready;
`endif

   // Ops are numbered by format group: R 0-13, I 14-19, shift-imm 20-22, LW, SW,
   // branches 25-30, JAL, JALR, LUI, AUIPC.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      enc_word  = 32'h0;
      enc_legal = 1'b1;
      f7        = 7'b0000000;
      case (src_op)
         6'd2, 6'd11, 6'd20, 6'd26:        f3 = 3'b001;
         6'd3, 6'd12, 6'd15, 6'd23, 6'd24: f3 = 3'b010;
         6'd4, 6'd13, 6'd16:               f3 = 3'b011;
         6'd5, 6'd17, 6'd27:               f3 = 3'b100;
         6'd6, 6'd7, 6'd21, 6'd22, 6'd28:  f3 = 3'b101;
         6'd8, 6'd18, 6'd29:               f3 = 3'b110;
         6'd9, 6'd19, 6'd30:               f3 = 3'b111;
         default:                          f3 = 3'b000;
      endcase

      if (src_op <= 6'd13) begin
         if (src_op == 6'd1 || src_op == 6'd7) f7 = 7'b0100000;
         else if (src_op >= 6'd10)             f7 = 7'b0000001;
         enc_word = {f7, src_rs2, src_rs1, f3, src_rd, 7'b0110011};
      end else if (src_op <= 6'd19) begin
         enc_word = {src_imm[11:0], src_rs1, f3, src_rd, 7'b0010011};
      end else if (src_op <= 6'd22) begin
         if (src_op == 6'd22) f7 = 7'b0100000;
         enc_word = {f7, src_imm[4:0], src_rs1, f3, src_rd, 7'b0010011};
      end else if (src_op == 6'd23) begin
         enc_word = {src_imm[11:0], src_rs1, f3, src_rd, 7'b0000011};
      end else if (src_op == 6'd24) begin
         enc_word = {src_imm[11:5], src_rs2, src_rs1, f3, src_imm[4:0], 7'b0100011};
      end else if (src_op <= 6'd30) begin
         enc_word = {src_imm[12], src_imm[10:5], src_rs2, src_rs1, f3,
                     src_imm[4:1], src_imm[11], 7'b1100011};
      end else if (src_op == 6'd31) begin
         enc_word = {src_imm[20], src_imm[10:1], src_imm[11], src_imm[19:12],
                     src_rd, 7'b1101111};
      end else if (src_op == 6'd32) begin
         enc_word = {src_imm[11:0], src_rs1, 3'b000, src_rd, 7'b1100111};
      end else if (src_op == 6'd33) begin
         enc_word = {src_imm[31:12], src_rd, 7'b0110111};
      end else if (src_op == 6'd34) begin
         enc_word = {src_imm[31:12], src_rd, 7'b0010111};
      end else begin
         enc_legal = 1'b0;
      end
   end

   assign push    = src_push && enc_legal;
   assign err_set = req_valid && req_ready && !enc_legal;
   assign pop     = !empty && inst_ready;

   // NOTE: FIFO storage is deliberately not reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= enc_word;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         emit_count  <= '0;
         err_illegal <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            emit_count <= emit_count + 1'b1;
         end
         if (err_set) err_illegal <= 1'b1;
      end
   end

   assign inst_valid  = !empty;
   assign instruction = empty ? STALL_NOP : mem[rd_ptr[AW-1:0]];

endmodule
